// File: rtl/int_mul.sv
// int_mul -- multi-lane unsigned shift-and-add multiplier.
//
// IN_NUM lanes are multiplied in lockstep. One operation is in flight at a
// time: IDLE accepts a pair of operands, BUSY performs one shift-and-add step
// per cycle, and DONE presents the registered products until they are taken.
//
// Parameters:
//   IN_NUM             number of parallel lanes
//   MULTIPLICAND_WIDTH unsigned operand A lane width
//   MULTIPLIER_WIDTH   unsigned operand B lane width (and the BUSY cycle count)
//   PRODUCT_WIDTH      product lane width (truncated or zero-extended)
//
// Ports:
//   clk                      clock, all state on the rising edge
//   rst                      asynchronous active-low reset
//   multiplicand_data[]      operand A per lane
//   multiplicand_data_valid  operand A valid
//   multiplicand_data_ready  operand A ready
//   multiplier_data[]        operand B per lane
//   multiplier_data_valid    operand B valid
//   multiplier_data_ready    operand B ready
//   product_data[]           registered product per lane
//   product_data_valid       product valid (shared by all lanes)
//   product_data_ready       product ready
//   debug_state              current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The two operand ports form a join: both readies rise only when both
// valids are high in IDLE, so both operands transfer on the same edge. Once
// product_data_valid is high, product_data is held stable until the edge on
// which product_data_ready is high.
//
// Configuration macro: INT_MUL_EARLY_EXIT_EN. When defined, BUSY ends as soon
// as every lane's remaining multiplier bits are zero; when undefined the
// latency is a fixed MULTIPLIER_WIDTH cycles.

module int_mul #(
    parameter int IN_NUM             = 8,
    parameter int MULTIPLICAND_WIDTH = 8,
    parameter int MULTIPLIER_WIDTH   = 8,
    parameter int PRODUCT_WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MULTIPLICAND_WIDTH-1:0] multiplicand_data [IN_NUM],
    input  logic                          multiplicand_data_valid,
    output logic                          multiplicand_data_ready,
    input  logic [MULTIPLIER_WIDTH-1:0]   multiplier_data [IN_NUM],
    input  logic                          multiplier_data_valid,
    output logic                          multiplier_data_ready,
    output logic [PRODUCT_WIDTH-1:0]      product_data [IN_NUM],
    output logic                          product_data_valid,
    input  logic                          product_data_ready,
    output logic [1:0]                    debug_state
);

    localparam int ACC_W = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;
    localparam int CNT_W = $clog2(MULTIPLIER_WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                    state;
    logic [CNT_W-1:0]              cnt;
    logic [MULTIPLICAND_WIDTH-1:0] a_reg    [IN_NUM];
    logic [MULTIPLIER_WIDTH-1:0]   b_reg    [IN_NUM];
    logic [ACC_W-1:0]              acc      [IN_NUM];
    logic [MULTIPLIER_WIDTH-1:0]   b_next   [IN_NUM];
    logic [ACC_W-1:0]              acc_next [IN_NUM];
    logic                          accept;
    logic                          busy_last;

    // rst gates the readies so nothing looks acceptable while reset is held.
    assign accept = (state == IDLE) && rst &&
                    multiplicand_data_valid && multiplier_data_valid;

    assign multiplicand_data_ready = accept;
    assign multiplier_data_ready   = accept;
    assign product_data_valid      = (state == DONE);
    assign debug_state             = state;

    // One shift-and-add step per lane.
    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            b_next[i]   = b_reg[i] >> 1;
            acc_next[i] = acc[i];
            if (b_reg[i][0]) begin
                acc_next[i] = acc[i] + (ACC_W'(a_reg[i]) << cnt);
            end
        end
    end

`ifdef INT_MUL_EARLY_EXIT_EN
    logic all_zero;

    // Nothing left to add in any lane once every shifted multiplier is zero.
    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < IN_NUM; i++) begin
            if (b_next[i] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    assign busy_last = all_zero || (cnt == CNT_W'(MULTIPLIER_WIDTH - 1));
`else
    assign busy_last = (cnt == CNT_W'(MULTIPLIER_WIDTH - 1));
`endif

    // The accumulator only changes in BUSY, so it doubles as the product
    // register and stays stable throughout DONE.
    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            product_data[i] = PRODUCT_WIDTH'(acc[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            for (int i = 0; i < IN_NUM; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
                acc[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        for (int i = 0; i < IN_NUM; i++) begin
                            a_reg[i] <= multiplicand_data[i];
                            b_reg[i] <= multiplier_data[i];
                            acc[i]   <= '0;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < IN_NUM; i++) begin
                        acc[i]   <= acc_next[i];
                        b_reg[i] <= b_next[i];
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (busy_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (product_data_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_mul.sv
// tb_int_mul -- directed bench for int_mul with default parameters, plus a
// PRODUCT_WIDTH=8 instance sharing the same inputs to check truncation.

module tb_int_mul;

    localparam int N = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  a_in [N];
    logic [7:0]  b_in [N];
    logic        a_v, b_v, p_rdy;
    logic        a_rdy, b_rdy, p_v;
    logic [15:0] p_out [N];
    logic [1:0]  st;
    logic        a_rdy8, b_rdy8, p_v8;
    logic [7:0]  p_out8 [N];
    logic [1:0]  st8;

    int compared   = 0;
    int mismatched = 0;

    int_mul dut (
        .clk                     (clk),
        .rst                     (rst),
        .multiplicand_data       (a_in),
        .multiplicand_data_valid (a_v),
        .multiplicand_data_ready (a_rdy),
        .multiplier_data         (b_in),
        .multiplier_data_valid   (b_v),
        .multiplier_data_ready   (b_rdy),
        .product_data            (p_out),
        .product_data_valid      (p_v),
        .product_data_ready      (p_rdy),
        .debug_state             (st)
    );

    int_mul #(.PRODUCT_WIDTH(8)) dut8 (
        .clk                     (clk),
        .rst                     (rst),
        .multiplicand_data       (a_in),
        .multiplicand_data_valid (a_v),
        .multiplicand_data_ready (a_rdy8),
        .multiplier_data         (b_in),
        .multiplier_data_valid   (b_v),
        .multiplier_data_ready   (b_rdy8),
        .product_data            (p_out8),
        .product_data_valid      (p_v8),
        .product_data_ready      (p_rdy),
        .debug_state             (st8)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][7:0]  a;
        logic [N-1:0][7:0]  b;
        logic [N-1:0][15:0] p;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Expected BUSY length; with early exit it is the position of the highest
    // set multiplier bit over all lanes, at least one cycle.
    function automatic int exp_lat(input logic [N-1:0][7:0] b);
`ifdef INT_MUL_EARLY_EXIT_EN
        int m = 1;
        for (int l = 0; l < N; l++)
            for (int k = 0; k < 8; k++)
                if (b[l][k] && (k + 1 > m)) m = k + 1;
        return m;
`else
        return 8;
`endif
    endfunction

    task automatic load(input int vi);
        for (int l = 0; l < N; l++) begin
            a_in[l] = vecs[vi].a[l];
            b_in[l] = vecs[vi].b[l];
        end
    endtask

    // Counts edges after the accept edge until product_data_valid; 0 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (p_v) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_products(input int vi);
        for (int l = 0; l < N; l++)
            check($sformatf("v%0d_lane%0d", vi, l), 32'(p_out[l]), 32'(vecs[vi].p[l]));
        check($sformatf("v%0d_narrow_lane0", vi), 32'(p_out8[0]), 32'(vecs[vi].p[0][7:0]));
    endtask

    task automatic run_op(input int vi);
        int lat;
        @(negedge clk);
        load(vi);
        a_v = 1'b1; b_v = 1'b1; p_rdy = 1'b1;
        #1;
        check("ready_a_idle", 32'(a_rdy), 32'd1);
        check("ready_b_idle", 32'(b_rdy), 32'd1);
        @(posedge clk); #1;
        a_v = 1'b0; b_v = 1'b0;
        check("ready_a_busy", 32'(a_rdy), 32'd0);
        check("state_busy", 32'(st), 32'd1);
        wait_valid(lat);
        check($sformatf("v%0d_latency", vi), 32'(lat), 32'(exp_lat(vecs[vi].b)));
        check_products(vi);
        @(posedge clk); #1;
        check("valid_one_cycle", 32'(p_v), 32'd0);
        check("state_idle_after", 32'(st), 32'd0);
    endtask

    initial begin
        int lat;
        int spurious;

        // lane order in the concatenations is lane7 ... lane0
        vecs[0].a = {N{8'd3}};
        vecs[0].b = {N{8'd5}};
        vecs[0].p = {N{16'd15}};
        vecs[1].a = {N{8'd255}};
        vecs[1].b = {N{8'd255}};
        vecs[1].p = {N{16'hFE01}};
        vecs[2].a = {8'd255, 8'd200, 8'd100, 8'd10, 8'd3, 8'd2, 8'd1, 8'd0};
        vecs[2].b = {8'd1, 8'd128, 8'd2, 8'd10, 8'd3, 8'd255, 8'd0, 8'd7};
        vecs[2].p = {16'd255, 16'd25600, 16'd200, 16'd100, 16'd9, 16'd510, 16'd0, 16'd0};
        vecs[3].a = {8'd128, 8'd64, 8'd32, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1};
        vecs[3].b = {N{8'd255}};
        vecs[3].p = {16'd32640, 16'd16320, 16'd8160, 16'd4080, 16'd2040, 16'd1020, 16'd510, 16'd255};
        vecs[4].a = {N{8'd17}};
        vecs[4].b = {N{8'd0}};
        vecs[4].p = {N{16'd0}};
        vecs[5].a = {N{8'd171}};
        vecs[5].b = {N{8'd205}};
        vecs[5].p = {N{16'd35055}};

        // Reset with both valids high: nothing may look ready.
        rst = 1'b0; a_v = 1'b1; b_v = 1'b1; p_rdy = 1'b0;
        load(0);
        repeat (3) @(negedge clk);
        check("rst_ready_a", 32'(a_rdy), 32'd0);
        check("rst_ready_b", 32'(b_rdy), 32'd0);
        check("rst_valid", 32'(p_v), 32'd0);
        check("rst_state", 32'(st), 32'd0);
        check("rst_prod0", 32'(p_out[0]), 32'd0);
        check("rst_prod7", 32'(p_out[7]), 32'd0);
        a_v = 1'b0; b_v = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Table of vectors.
        for (int vi = 0; vi < NV; vi++) run_op(vi);

        // Lone multiplicand valid is never accepted.
        @(negedge clk);
        load(0);
        a_v = 1'b1; b_v = 1'b0; p_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("join_ready_a", 32'(a_rdy), 32'd0);
            check("join_ready_b", 32'(b_rdy), 32'd0);
            check("join_state", 32'(st), 32'd0);
        end
        @(negedge clk);
        b_v = 1'b1;
        #1;
        check("join_ready_a_both", 32'(a_rdy), 32'd1);
        check("join_ready_b_both", 32'(b_rdy), 32'd1);
        @(posedge clk); #1;
        a_v = 1'b0; b_v = 1'b0;
        check("join_accept", 32'(st), 32'd1);
        wait_valid(lat);
        check("join_latency", 32'(lat), 32'(exp_lat(vecs[0].b)));
        check_products(0);
        @(posedge clk); #1;

        // Product backpressure for 5 cycles; valids held high meanwhile.
        @(negedge clk);
        load(5);
        a_v = 1'b1; b_v = 1'b1; p_rdy = 1'b0;
        @(posedge clk); #1;
        check("bp_accept", 32'(st), 32'd1);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'(exp_lat(vecs[5].b)));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_valid_held", 32'(p_v), 32'd1);
            check("bp_lane0_held", 32'(p_out[0]), 32'd35055);
            check("bp_lane7_held", 32'(p_out[7]), 32'd35055);
            check("bp_ready_a_low", 32'(a_rdy), 32'd0);
            check("bp_ready_b_low", 32'(b_rdy), 32'd0);
        end
        @(negedge clk);
        a_v = 1'b0; b_v = 1'b0; p_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", 32'(p_v), 32'd0);
        check("bp_state_idle", 32'(st), 32'd0);

        // Asynchronous reset during BUSY discards the operation.
        @(negedge clk);
        load(1);
        a_v = 1'b1; b_v = 1'b1;
        @(posedge clk); #1;
        a_v = 1'b0; b_v = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_state", 32'(st), 32'd0);
        check("mid_rst_valid", 32'(p_v), 32'd0);
        check("mid_rst_prod0", 32'(p_out[0]), 32'd0);
        check("mid_rst_ready", 32'(a_rdy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        spurious = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (p_v) spurious++;
        end
        check("no_spurious_valid", 32'(spurious), 32'd0);

        // Recovery after reset.
        run_op(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
